// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: Set-2 prefix bytes, frame FSM states and
// parity-mode encodings.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // Check over the eight data bits plus the received parity bit.
    function automatic logic parity_ok(int mode, logic [7:0] sh, logic p);
        case (mode)
            PAR_ODD:  return ^{sh, p};
            PAR_EVEN: return ~^{sh, p};
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Key-event bus from the PS/2 receiver to the keyboard-matrix mapper.
interface ps2_scancode_rx_if;

    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_BREAK;
    logic       KEY_VALID;
    logic       FRAME_ERR;

    modport master (output KEY_CODE, KEY_EXT, KEY_BREAK, KEY_VALID, FRAME_ERR);
    modport slave  (input  KEY_CODE, KEY_EXT, KEY_BREAK, KEY_VALID, FRAME_ERR);

endinterface

// File: rtl/ps2_pin_filter.sv
// Two-flop synchroniser plus glitch filter for one raw PS/2 pin; the filtered
// level changes only after FILTER_LEN consecutive samples disagree with it.
module ps2_pin_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchroniser and filter preset to 1 so reset never fakes a falling edge.
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pin_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with Set-2 E0/F0 prefix decoding; emits one
// key event (code, extended, break) per non-prefix byte.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT     = 20000,
    parameter int PARITY_MODE = PAR_ODD
) (
    input  logic                      CLK100MHZ,
    input  logic                      RESET,
    input  logic                      PS2_CLK,
    input  logic                      PS2_DATA,
    ps2_scancode_rx_if.master         key_if
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic clk_fall, clk_level_unused;
    logic data_level, data_fall_unused;

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(CLK100MHZ), .rst(RESET), .pin_i(PS2_CLK),
        .level_o(clk_level_unused), .fall_o(clk_fall)
    );

    ps2_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(CLK100MHZ), .rst(RESET), .pin_i(PS2_DATA),
        .level_o(data_level), .fall_o(data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    code_q, code_d;
    logic          kext_q, kext_d, kbrk_q, kbrk_d;
    logic          valid_q, valid_d, err_q, err_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sh_d     = sh_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        code_d   = code_q;
        kext_d   = kext_q;
        kbrk_d   = kbrk_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (clk_fall || state_q == IDLE) begin
            tmo_d = '0;
        end else if (tmo_q != TW'(TIMEOUT)) begin
            tmo_d = tmo_q + 1'b1;
        end

        // A stalled frame wins over a coincident edge; the partial byte is dropped.
        if (state_q != IDLE && tmo_q == TW'(TIMEOUT)) begin
            state_d = IDLE;
            tmo_d   = '0;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end else if (clk_fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_level) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                DATA: begin
                    sh_d     = {data_level, sh_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = data_level;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_level && parity_ok(PARITY_MODE, sh_q, par_q)) begin
                        if (sh_q == PS2_PFX_EXT) begin
                            ext_d = 1'b1;
                        end else if (sh_q == PS2_PFX_BRK) begin
                            brk_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            code_d  = sh_q;
                            kext_d  = ext_q;
                            kbrk_d  = brk_q;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            code_q   <= '0;
            kext_q   <= 1'b0;
            kbrk_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            code_q   <= code_d;
            kext_q   <= kext_d;
            kbrk_q   <= kbrk_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign key_if.KEY_CODE  = code_q;
    assign key_if.KEY_EXT   = kext_q;
    assign key_if.KEY_BREAK = kbrk_q;
    assign key_if.KEY_VALID = valid_q;
    assign key_if.FRAME_ERR = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: an odd-parity and a no-parity receiver share the same
// PS/2 pins; key events are compared against a byte-level model of the Set-2 protocol.
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    always #5 clk = ~clk;

    ps2_scancode_rx_if bus1 ();
    ps2_scancode_rx_if bus0 ();

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .PARITY_MODE(PAR_ODD)) dut (
        .CLK100MHZ(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .key_if(bus1.master)
    );

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO), .PARITY_MODE(PAR_NONE)) dut_np (
        .CLK100MHZ(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .key_if(bus0.master)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t act1_q[$], act0_q[$], exp1_q[$], exp0_q[$];
    int  act_err[2] = '{0, 0};
    int  exp_err[2] = '{0, 0};
    bit  exp_ext[2] = '{0, 0};
    bit  exp_brk[2] = '{0, 0};
    int  total = 0;
    int  bad = 0;
    logic prev_v1 = 1'b0;
    logic prev_v0 = 1'b0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Event capture plus the always-on properties: no VALID+ERR overlap, VALID lasts one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.KEY_VALID) act1_q.push_back({bus1.KEY_CODE, bus1.KEY_EXT, bus1.KEY_BREAK});
            if (bus0.KEY_VALID) act0_q.push_back({bus0.KEY_CODE, bus0.KEY_EXT, bus0.KEY_BREAK});
            if (bus1.FRAME_ERR) act_err[1]++;
            if (bus0.FRAME_ERR) act_err[0]++;
            if (bus1.KEY_VALID || bus1.FRAME_ERR)
                check("excl_odd", 32'(bus1.KEY_VALID & bus1.FRAME_ERR), 32'd0);
            if (bus0.KEY_VALID || bus0.FRAME_ERR)
                check("excl_nopar", 32'(bus0.KEY_VALID & bus0.FRAME_ERR), 32'd0);
            if (bus1.KEY_VALID) check("pulse_odd", 32'(prev_v1), 32'd0);
            if (bus0.KEY_VALID) check("pulse_nopar", 32'(prev_v0), 32'd0);
        end
        prev_v1 = bus1.KEY_VALID;
        prev_v0 = bus0.KEY_VALID;
    end

    // Protocol model at byte granularity; index 1 = odd-parity receiver, 0 = parity ignored.
    task automatic model_frame(logic [7:0] b, bit bad_par, bit bad_stop, bit trunc);
        for (int m = 0; m < 2; m++) begin
            bit good;
            good = !bad_stop && !trunc && (m == 0 || !bad_par);
            if (!good) begin
                exp_err[m]++;
                exp_ext[m] = 1'b0;
                exp_brk[m] = 1'b0;
            end else if (b == 8'hE0) begin
                exp_ext[m] = 1'b1;
            end else if (b == 8'hF0) begin
                exp_brk[m] = 1'b1;
            end else begin
                if (m == 1) exp1_q.push_back({b, exp_ext[m], exp_brk[m]});
                else        exp0_q.push_back({b, exp_ext[m], exp_brk[m]});
                exp_ext[m] = 1'b0;
                exp_brk[m] = 1'b0;
            end
        end
    endtask

    // One bit cell: data changes mid-high phase, optional 1-cycle clock glitch before it.
    task automatic send_bit(logic b, bit glitch);
        repeat (HALF / 4) @(posedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            @(posedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF / 4) @(posedge clk);
        ps2_data = b;
        repeat (HALF / 2) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop, bit glitch);
        logic p;
        p = (~^b) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(~bad_stop, glitch);
        repeat (HALF / 2) @(posedge clk);
        ps2_data = 1'b1;
        repeat (40) @(posedge clk);
        model_frame(b, bad_par, bad_stop, 1'b0);
    endtask

    task automatic cmp_q(string tag, input ev_t a[$], input ev_t e[$]);
        check({tag, "_count"}, 32'(a.size()), 32'(e.size()));
        for (int i = 0; i < a.size() && i < e.size(); i++) begin
            check({tag, "_code"}, 32'(a[i].code), 32'(e[i].code));
            check({tag, "_ext"},  32'(a[i].ext),  32'(e[i].ext));
            check({tag, "_brk"},  32'(a[i].brk),  32'(e[i].brk));
        end
    endtask

    task automatic check_events(string tag);
        @(negedge clk);
        cmp_q({tag, "_odd"}, act1_q, exp1_q);
        cmp_q({tag, "_nopar"}, act0_q, exp0_q);
        check({tag, "_err_odd"}, 32'(act_err[1]), 32'(exp_err[1]));
        check({tag, "_err_nopar"}, 32'(act_err[0]), 32'(exp_err[0]));
        act1_q.delete();
        act0_q.delete();
        exp1_q.delete();
        exp0_q.delete();
    endtask

    task automatic check_outputs_zero(string tag);
        @(negedge clk);
        check({tag, "_code"}, 32'(bus1.KEY_CODE), 32'd0);
        check({tag, "_flags"}, 32'({bus1.KEY_EXT, bus1.KEY_BREAK, bus1.KEY_VALID, bus1.FRAME_ERR}), 32'd0);
        check({tag, "_code_np"}, 32'(bus0.KEY_CODE), 32'd0);
        check({tag, "_flags_np"}, 32'({bus0.KEY_EXT, bus0.KEY_BREAK, bus0.KEY_VALID, bus0.FRAME_ERR}), 32'd0);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] code;
        int         pfx;
        bit         bpar;

        repeat (5) @(posedge clk);
        rst = 1'b0;
        check_outputs_zero("reset");

        send_frame(8'h1C, 0, 0, 0);
        check_events("single_1c");

        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        check_events("break_1c");
        send_frame(8'h1C, 0, 0, 0);
        check_events("make_after_break");

        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        check_events("ext_break_75");
        send_frame(8'h5A, 0, 0, 0);
        check_events("after_ext_break");

        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h6B, 0, 0, 0);
        check_events("repeat_e0");

        send_frame(8'h5A, 1, 0, 0);
        check_events("bad_parity");
        send_frame(8'h5A, 0, 1, 0);
        check_events("bad_stop");

        send_frame(8'hE0, 0, 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        repeat (HALF / 2) @(posedge clk);
        ps2_data = 1'b1;
        repeat (TO + 100) @(posedge clk);
        model_frame(8'h00, 0, 0, 1);
        check_events("timeout");
        send_frame(8'h5A, 0, 0, 0);
        check_events("after_timeout");

        send_frame(8'h1C, 0, 0, 1);
        check_events("glitch_1c");

        send_frame(8'hE0, 0, 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        ps2_data = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        exp_ext = '{0, 0};
        exp_brk = '{0, 0};
        check_outputs_zero("mid_reset");
        repeat (20) @(posedge clk);
        check_events("mid_reset_quiet");
        send_frame(8'h1C, 0, 0, 0);
        check_events("after_reset_1c");

        for (int n = 0; n < 14; n++) begin
            pfx  = int'($urandom_range(0, 3));
            code = 8'($urandom_range(0, 255));
            if (code == 8'hE0 || code == 8'hF0) code = code ^ 8'h01;
            bpar = ($urandom_range(0, 5) == 0);
            if (pfx[0]) send_frame(8'hE0, 0, 0, 0);
            if (pfx[1]) send_frame(8'hF0, 0, 0, 0);
            send_frame(code, bpar, 0, 0);
            check_events("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
